dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder for the single-cycle RISC-V core's load/store port. It is the memory side of the core's address/write-data/write-enable interface. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs byte, halfword and word accesses selected by the RISC-V funct3 code, sign- or zero-extending loads, and reports misaligned, illegal or out-of-range accesses. A combinational debug read port mirrors the register-file debug port.

Parameters:
ADDR_W, 10, word-address width; the array holds 2^ADDR_W 32-bit words, so the byte range is 0 .. 2^(ADDR_W+2)-1.
WAIT_CYCLES, 1, wait states between accept and response; legal range 0..15.

Ports:
clk  input  1  clock; rising edge active.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
req_funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
rsp_valid  output  1  one-cycle response strobe.
rsp_rdata  output  32  extended load data; 0 for stores and for errors.
rsp_err  output  1  access rejected.
dbg_addr  input  ADDR_W  debug word address.
dbg_data  output  32  combinational read of the word at dbg_addr.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- On reset: state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 in the cycle after reset. Array contents are not cleared.
- Reset mid-transaction abandons the request. No store is committed and no response is issued.
- FSM states: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE.
  - Request inputs are ignored outside IDLE.
- IDLE: when req_valid=1, the accept edge latches we/addr/wdata/funct3.
  - WAIT_CYCLES=0: go to RESP.
  - Otherwise: go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; go to RESP on the edge where counter==0.
- Access edge: the edge that enters RESP. At this edge:
  - the load is read from pre-edge array contents;
  - store byte lanes are written;
  - rsp_rdata and rsp_err are registered.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- rsp_rdata and rsp_err are 0 whenever rsp_valid=0.
- Latency: accept edge at cycle T, rsp_valid high in cycle T+1+WAIT_CYCLES. Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- Word index is addr[ADDR_W+1:2]. Byte lane is addr[1:0].
  - sb writes lane addr[1:0].
  - sh writes lanes {addr[1],0} and {addr[1],1}.
  - sw writes all four lanes.
  - Unwritten lanes are preserved.
- Loads:
  - lb/lh sign-extend from bit 7/15 of the selected lane(s).
  - lbu/lhu zero-extend.
  - lw returns the full word.
- Error (rsp_err=1, rsp_rdata=0, no write) if any of:
  - h/hu with addr[0]=1;
  - w with addr[1:0]!=0;
  - funct3 in {011, 110, 111};
  - store with funct3 100 or 101;
  - addr[31:ADDR_W+2] != 0.
- Stores that succeed return rsp_err=0, rsp_rdata=0.
- dbg_data is purely combinational and reflects a store from the cycle after the access edge.

Test Plan:
1. WAIT_CYCLES=1: sw 0xDEADBEEF @0x10, accepted at T -> rsp_valid only in T+2, rsp_err=0; dbg_addr=4 -> 0xDEADBEEF. Then lw @0x10 -> rsp_rdata=0xDEADBEEF.
2. After 1: sb wdata=0x00000080 @0x13 -> lw @0x10 = 0x80ADBEEF; lb @0x13 = 0xFFFFFF80; lbu @0x13 = 0x00000080.
3. After 2: sh wdata=0x00001234 @0x12 -> lw @0x10 = 0x1234BEEF; lh @0x12 = 0x00001234; lhu @0x10 = 0x0000BEEF.
4. Errors: lw @0x11, sh @0x13, funct3=011, sb @0x1000 (ADDR_W=10) -> rsp_err=1, rsp_rdata=0, word 4 unchanged.
5. req_valid held high continuously with alternating requests -> each accepted only while req_ready=1; WAIT_CYCLES=0 gives a response every 2nd cycle; WAIT_CYCLES=3 gives a response every 5th cycle.
6. Assert reset during WAIT of sw 0x11111111 @0x20 -> rsp_valid never asserted, word 8 unchanged, req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: valid/ready request,
// fixed wait states, byte/half/word access with extension and error reporting.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q, wdata_q;
  logic [2:0]        f3_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem_q [2**ADDR_W];

  logic              access;
  logic              a_we;
  logic [31:0]       a_addr, a_wdata;
  logic [2:0]        a_f3;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       lane_word;
  logic              bad_op, acc_err;
  logic [3:0]        be;
  logic [31:0]       wd_lanes;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_data  = mem_q[dbg_addr];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (WAIT_CYCLES == 0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        state_d = S_RESP;
        access  = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With no wait states the access happens on the accept edge, so the live
  // request fields are used instead of the latched copy.
  always_comb begin
    a_we     = req_ready ? req_we     : we_q;
    a_addr   = req_ready ? req_addr   : addr_q;
    a_wdata  = req_ready ? req_wdata  : wdata_q;
    a_f3     = req_ready ? req_funct3 : f3_q;
    word_idx = a_addr[ADDR_W+1:2];
    case (a_f3)
      3'b000:  bad_op = 1'b0;
      3'b100:  bad_op = a_we;
      3'b001:  bad_op = a_addr[0];
      3'b101:  bad_op = a_we | a_addr[0];
      3'b010:  bad_op = |a_addr[1:0];
      default: bad_op = 1'b1;
    endcase
    acc_err   = bad_op | (a_addr[31:ADDR_W+2] != '0);
    lane_word = mem_q[word_idx] >> {a_addr[1:0], 3'b000};
    be        = byte_en(a_f3[1:0], a_addr[1:0]);
    wd_lanes  = store_lanes(a_f3[1:0], a_wdata);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        rdata_q <= (acc_err || a_we) ? 32'd0 : load_ext(a_f3, lane_word);
        err_q   <= acc_err;
      end else begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_ready && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      f3_q    <= req_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && access && a_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wd_lanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 0 and 3 wait states) with a
// per-instance scoreboard checked on every falling edge.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mon_en;
  logic [2:0]  vld, rdy, we, rv, re;
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [31:0] rd   [3];
  logic [31:0] dbgd [3];
  logic [2:0]  f3   [3];
  logic [9:0]  dbga [3];
  logic [31:0] exp_rd  [3];
  logic        exp_err [3];
  logic [31:0] last [3];
  exp_t        q0[$], q1[$], q2[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_addr(addr[0]), .req_wdata(wd[0]), .req_funct3(f3[0]), .rsp_valid(rv[0]),
    .rsp_rdata(rd[0]), .rsp_err(re[0]), .dbg_addr(dbga[0]), .dbg_data(dbgd[0]));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_addr(addr[1]), .req_wdata(wd[1]), .req_funct3(f3[1]), .rsp_valid(rv[1]),
    .rsp_rdata(rd[1]), .rsp_err(re[1]), .dbg_addr(dbga[1]), .dbg_data(dbgd[1]));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we[2]),
    .req_addr(addr[2]), .req_wdata(wd[2]), .req_funct3(f3[2]), .rsp_valid(rv[2]),
    .rsp_rdata(rd[2]), .rsp_err(re[2]), .dbg_addr(dbga[2]), .dbg_data(dbgd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 500000", $time);
    $fatal(1, "watchdog");
  end

  function automatic int wc(int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t qpop(int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qclear(int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: expectations ride with the request and are queued on acceptance.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (rst) qclear(k);
        else if (vld[k] && rdy[k]) qpush(k, '{rd: exp_rd[k], err: exp_err[k], acc: cyc});
        if (rv[k]) begin
          if (qsize(k) == 0) begin
            chk($sformatf("dut%0d unexpected rsp_valid", k), {31'd0, rv[k]}, 32'd0);
          end else begin
            e = qpop(k);
            chk($sformatf("dut%0d rsp_rdata", k), rd[k], e.rd);
            chk($sformatf("dut%0d rsp_err", k), {31'd0, re[k]}, {31'd0, e.err});
            chk($sformatf("dut%0d latency", k), cyc, e.acc + 1 + wc(k));
          end
        end else begin
          chk($sformatf("dut%0d idle rdata", k), rd[k], 32'd0);
          chk($sformatf("dut%0d idle err", k), {31'd0, re[k]}, 32'd0);
        end
      end
    end
  end

  task automatic req0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic [31:0] er, input logic ee);
    int t;
    @(posedge clk); #1;
    we[0] = w; addr[0] = a; wd[0] = d; f3[0] = f;
    exp_rd[0] = er; exp_err[0] = ee; vld[0] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rdy[0] && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    vld[0] = 1'b0;
    t = 0;
    while (t < 50) begin
      @(negedge clk); #1;
      if (qsize(0) == 0) break;
      t++;
    end
    chk("response pending", qsize(0), 32'd0);
  endtask

  task automatic set_req(input int k, input int i);
    if (i % 2 == 0) begin
      we[k] = 1'b1; addr[k] = 32'h40; f3[k] = 3'b010;
      wd[k] = 32'h5A000000 | (k << 16) | i;
      exp_rd[k] = 32'd0; exp_err[k] = 1'b0;
      last[k] = wd[k];
    end else begin
      we[k] = 1'b0; addr[k] = 32'h40; f3[k] = 3'b010; wd[k] = 32'd0;
      exp_rd[k] = last[k]; exp_err[k] = 1'b0;
    end
  endtask

  initial begin
    int idx [3];
    int nacc [3];
    int nrsp [3];
    logic acc [3];
    rst = 1'b1; mon_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wd[k] = 32'd0; f3[k] = 3'd0;
      dbga[k] = 10'd0; exp_rd[k] = 32'd0; exp_err[k] = 1'b0; last[k] = 32'd0;
      idx[k] = 0; nacc[k] = 0; nrsp[k] = 0; acc[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d reset req_ready", k), {31'd0, rdy[k]}, 32'd1);
      chk($sformatf("dut%0d reset rsp_valid", k), {31'd0, rv[k]}, 32'd0);
      chk($sformatf("dut%0d reset rsp_rdata", k), rd[k], 32'd0);
      chk($sformatf("dut%0d reset rsp_err", k), {31'd0, re[k]}, 32'd0);
    end
    mon_en = 1'b1;

    // word store, debug port, word load
    req0(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0);
    dbga[0] = 10'd4; #1;
    chk("dbg word4 after sw", dbgd[0], 32'hDEADBEEF);
    req0(1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0);

    // byte store and byte loads
    req0(1'b1, 32'h13, 32'h00000080, 3'b000, 32'd0, 1'b0);
    req0(1'b0, 32'h10, 32'd0, 3'b010, 32'h80ADBEEF, 1'b0);
    req0(1'b0, 32'h13, 32'd0, 3'b000, 32'hFFFFFF80, 1'b0);
    req0(1'b0, 32'h13, 32'd0, 3'b100, 32'h00000080, 1'b0);
    req0(1'b0, 32'h10, 32'd0, 3'b000, 32'hFFFFFFEF, 1'b0);

    // halfword store and halfword loads
    req0(1'b1, 32'h12, 32'h00001234, 3'b001, 32'd0, 1'b0);
    req0(1'b0, 32'h10, 32'd0, 3'b010, 32'h1234BEEF, 1'b0);
    req0(1'b0, 32'h12, 32'd0, 3'b001, 32'h00001234, 1'b0);
    req0(1'b0, 32'h10, 32'd0, 3'b101, 32'h0000BEEF, 1'b0);
    req0(1'b0, 32'h10, 32'd0, 3'b001, 32'hFFFFBEEF, 1'b0);

    // rejected accesses
    req0(1'b0, 32'h11, 32'd0, 3'b010, 32'd0, 1'b1);
    req0(1'b1, 32'h13, 32'hFFFFFFFF, 3'b001, 32'd0, 1'b1);
    req0(1'b0, 32'h10, 32'd0, 3'b011, 32'd0, 1'b1);
    req0(1'b1, 32'h1000, 32'hFFFFFFFF, 3'b000, 32'd0, 1'b1);
    req0(1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'd0, 1'b1);
    req0(1'b1, 32'h10, 32'hFFFFFFFF, 3'b010, 32'd0, 1'b0);
    req0(1'b0, 32'h2000, 32'd0, 3'b010, 32'd0, 1'b1);
    req0(1'b0, 32'h12, 32'd0, 3'b111, 32'd0, 1'b1);
    dbga[0] = 10'd4; #1;
    chk("dbg word4 after good sw", dbgd[0], 32'hFFFFFFFF);
    req0(1'b1, 32'h10, 32'h1234BEEF, 3'b010, 32'd0, 1'b0);
    req0(1'b1, 32'h12, 32'h0000AAAA, 3'b110, 32'd0, 1'b1);
    req0(1'b0, 32'h10, 32'd0, 3'b010, 32'h1234BEEF, 1'b0);
    #1;
    chk("dbg word4 after errors", dbgd[0], 32'h1234BEEF);

    // back-to-back requests with valid held high on the 0- and 3-wait instances
    @(posedge clk); #1;
    for (int k = 1; k < 3; k++) begin
      set_req(k, 0);
      vld[k] = 1'b1;
    end
    repeat (20) begin
      @(negedge clk);
      for (int k = 1; k < 3; k++) begin
        acc[k] = rdy[k];
        if (rdy[k]) nacc[k]++;
        if (rv[k]) nrsp[k]++;
      end
      @(posedge clk); #1;
      for (int k = 1; k < 3; k++) begin
        if (acc[k]) begin
          idx[k]++;
          set_req(k, idx[k]);
        end
      end
    end
    vld[1] = 1'b0; vld[2] = 1'b0;
    chk("wait0 accepts in 20 cycles", nacc[1], 32'd10);
    chk("wait0 responses in 20 cycles", nrsp[1], 32'd10);
    chk("wait3 accepts in 20 cycles", nacc[2], 32'd4);
    chk("wait3 responses in 20 cycles", nrsp[2], 32'd4);
    repeat (6) @(negedge clk);

    // reset while a store is waiting
    req0(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'd0, 1'b0);
    @(posedge clk); #1;
    we[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h11111111; f3[0] = 3'b010;
    exp_rd[0] = 32'd0; exp_err[0] = 1'b0; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready after mid-wait reset", {31'd0, rdy[0]}, 32'd1);
    repeat (6) @(negedge clk);
    dbga[0] = 10'd8; #1;
    chk("dbg word8 after abandoned sw", dbgd[0], 32'hCAFEF00D);
    req0(1'b0, 32'h20, 32'd0, 3'b010, 32'hCAFEF00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
